// File: rtl/cu_data_read_extract_control.sv
// Reassembles tagged half-cacheline reads, extracts and byte-swaps the addressed element,
// and queues results in a first-word-fall-through FIFO with ready/valid backpressure.

module cu_rd_slot #(
  parameter int HALF_W = 512,
  parameter int ID_W   = 32,
  parameter int CUID_W = 8,
  parameter int OFF_W  = 8
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              wr0,
  input  logic              wr1,
  input  logic              clr,
  input  logic [HALF_W-1:0] data0_in,
  input  logic [HALF_W-1:0] data1_in,
  input  logic [OFF_W-1:0]  offset_in,
  input  logic [ID_W-1:0]   id_in,
  input  logic [CUID_W-1:0] cu_id_in,
  output logic              have0,
  output logic              have1,
  output logic              dup,
  output logic [HALF_W-1:0] data0,
  output logic [HALF_W-1:0] data1,
  output logic [OFF_W-1:0]  offset,
  output logic [ID_W-1:0]   id,
  output logic [CUID_W-1:0] cu_id
);
  // a half landing on an already-held half is dropped and only flagged
  assign dup = (wr0 && have0) || (wr1 && have1);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      have0 <= 1'b0;
      have1 <= 1'b0;
    end else begin
      have0 <= clr ? 1'b0 : (have0 | wr0);
      have1 <= clr ? 1'b0 : (have1 | wr1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr0 && !have0) begin
      data0  <= data0_in;
      offset <= offset_in;
      id     <= id_in;
      cu_id  <= cu_id_in;
    end
    if (wr1 && !have1) data1 <= data1_in;
  end
endmodule

module cu_data_read_extract_control #(
  parameter int HALF_W      = 512,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 32,
  parameter int CUID_W      = 8,
  parameter int OFF_W       = 8,
  parameter int TAG_W       = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter bit SWAP_ENDIAN = 1'b1
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  input  logic              rd0_valid,
  input  logic [TAG_W-1:0]  rd0_tag,
  input  logic [HALF_W-1:0] rd0_data,
  input  logic [OFF_W-1:0]  rd0_offset,
  input  logic [ID_W-1:0]   rd0_id,
  input  logic [CUID_W-1:0] rd0_cu_id,
  input  logic              rd1_valid,
  input  logic [TAG_W-1:0]  rd1_tag,
  input  logic [HALF_W-1:0] rd1_data,
  output logic              edge_valid,
  input  logic              edge_ready,
  output logic [DATA_W-1:0] edge_data,
  output logic [ID_W-1:0]   edge_id,
  output logic [CUID_W-1:0] edge_cu_id,
  output logic [TAG_W:0]    pending_cnt,
  output logic              fifo_full,
  output logic              err_dup
);
  localparam int SLOTS = 2**TAG_W;
  localparam int E     = 2*HALF_W/DATA_W;
  localparam int IDX_W = $clog2(E);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic [CUID_W-1:0] cu_id;
  } edge_t;

  logic enabled;
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) enabled <= 1'b0;
    else       enabled <= enabled_in;

  logic [SLOTS-1:0]             wr0, wr1, clr, have0, have1, dup;
  logic [SLOTS-1:0][HALF_W-1:0] s_data0, s_data1;
  logic [SLOTS-1:0][OFF_W-1:0]  s_off;
  logic [SLOTS-1:0][ID_W-1:0]   s_id;
  logic [SLOTS-1:0][CUID_W-1:0] s_cu;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign wr0[i] = enabled && rd0_valid && (rd0_tag == TAG_W'(i));
    assign wr1[i] = enabled && rd1_valid && (rd1_tag == TAG_W'(i));
    cu_rd_slot #(.HALF_W(HALF_W), .ID_W(ID_W), .CUID_W(CUID_W), .OFF_W(OFF_W)) u_slot (
      .clock(clock), .rstn(rstn), .wr0(wr0[i]), .wr1(wr1[i]), .clr(clr[i]),
      .data0_in(rd0_data), .data1_in(rd1_data), .offset_in(rd0_offset),
      .id_in(rd0_id), .cu_id_in(rd0_cu_id), .have0(have0[i]), .have1(have1[i]),
      .dup(dup[i]), .data0(s_data0[i]), .data1(s_data1[i]), .offset(s_off[i]),
      .id(s_id[i]), .cu_id(s_cu[i]));
  end

  // FIFO bookkeeping
  logic [PTR_W:0] wptr, rptr;
  logic [CNT_W-1:0] count, cnt_after;
  logic push, pop, space;
  edge_t mem [FIFO_DEPTH];
  edge_t head, pick_entry;

  assign count      = wptr - rptr;
  assign edge_valid = enabled && (count != '0);
  assign pop        = edge_valid && edge_ready;
  assign cnt_after  = count - CNT_W'(pop);
  assign space      = cnt_after < CNT_W'(FIFO_DEPTH);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // lowest-index complete slot wins
  logic [SLOTS-1:0] complete;
  logic [TAG_W-1:0] pick_sel;
  logic             pick_any;
  assign complete = have0 & have1;

  always_comb begin
    pick_any = 1'b0;
    pick_sel = '0;
    for (int i = SLOTS-1; i >= 0; i--)
      if (complete[i]) begin
        pick_any = 1'b1;
        pick_sel = i[TAG_W-1:0];
      end
  end

  assign push = enabled && pick_any && space;
  assign clr  = push ? (SLOTS'(1) << pick_sel) : '0;

  logic [2*HALF_W-1:0] line;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   elem, elem_sw;

  assign line = {s_data1[pick_sel], s_data0[pick_sel]};
  assign idx  = IDX_W'(s_off[pick_sel]);
  assign elem = line[DATA_W*idx +: DATA_W];

  for (genvar b = 0; b < DATA_W/8; b++) begin : g_swap
    assign elem_sw[8*b +: 8] = SWAP_ENDIAN ? elem[DATA_W-8-8*b +: 8] : elem[8*b +: 8];
  end

  assign pick_entry = '{data: elem_sw, id: s_id[pick_sel], cu_id: s_cu[pick_sel]};

  always_ff @(posedge clock)
    if (push) mem[wptr[PTR_W-1:0]] <= pick_entry;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      err_dup <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (|dup) err_dup <= 1'b1;
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < SLOTS; i++)
      pending_cnt = pending_cnt + (TAG_W+1)'(have0[i] | have1[i]);
  end

  // gate the head so outputs read zero while empty or disabled
  assign head       = mem[rptr[PTR_W-1:0]];
  assign edge_data  = edge_valid ? head.data  : '0;
  assign edge_id    = edge_valid ? head.id    : '0;
  assign edge_cu_id = edge_valid ? head.cu_id : '0;
endmodule
